// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and defaults for the ALU control blocks
//
// Purpose : FSM state encoding and the default button debounce length,
//           shared by the operand loader and later ALU control blocks.
// Ports   : none (package)

package alu_pkg;

  // 2'b11 is deliberately left unencoded; FSMs recover from it to WAIT_A.
  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    PRESENT = 2'b10
  } alu_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer, debounce counter, rising-edge pulse
//
// Purpose : Turns a raw, asynchronous, bouncing active-high button into a
//           single-cycle pulse on each accepted 0->1 level change.
// Ports   : clk     - clock
//           rst_n   - asynchronous active-low reset
//           i_btn   - raw button input
//           o_pulse - one-cycle pulse after a debounced rising edge

module button_debouncer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1, so it cannot wrap.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Registered edge detect: adds one cycle so capture lands on the
      // (DEBOUNCE_CYCLES+3)th edge after the button is first sampled high.
      r_pulse   <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - captures two switch operands and presents them downstream
//
// Purpose : Load button captures sw_data into op_a, then op_b; the pair is
//           then held with op_valid until op_ready completes a handshake.
//           Clear button zeroes the operands and returns to WAIT_A.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           sw_data[7:0]          - operand value from switches
//           btn_load, btn_clear   - raw bouncing buttons
//           op_a, op_b [7:0]      - captured operands
//           op_valid / op_ready   - downstream handshake
//           state[1:0]            - current FSM state for LEDs

module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_data,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] state
);

  logic       w_load_pulse;
  logic       w_clear_pulse;

  alu_state_e r_state;
  alu_state_e w_state_nxt;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic [7:0] w_op_a_nxt;
  logic [7:0] w_op_b_nxt;
  logic       r_valid;
  logic       w_valid_nxt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_load),
    .o_pulse (w_load_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_clear),
    .o_pulse (w_clear_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_A;
      r_op_a  <= 8'h00;
      r_op_b  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_valid_nxt = r_valid;
    // Clear wins over load; with op_ready in PRESENT the transfer is
    // considered complete and the clear result is identical.
    if (w_clear_pulse) begin
      w_state_nxt = WAIT_A;
      w_op_a_nxt  = 8'h00;
      w_op_b_nxt  = 8'h00;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (w_load_pulse) begin
            w_op_a_nxt  = sw_data;
            w_state_nxt = WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_load_pulse) begin
            w_op_b_nxt  = sw_data;
            w_state_nxt = PRESENT;
            w_valid_nxt = 1'b1;
          end
        end
        PRESENT: begin
          if (r_valid && op_ready) begin
            w_state_nxt = WAIT_A;
            w_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = WAIT_A;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_valid = r_valid;
  assign state    = r_state;

endmodule
